spi_slave_if: RTL and testbench

Parametrised SPI slave front-end, the successor of the fixed 10-bit slave interface. It sits between an SPI master and the RAM/register block. It deserialises command frames of width 2+DATA_W from MOSI into `rx_data`, tracks the read-address/read-data sequence, and serialises returned read data onto MISO with a ready/valid handshake. It adds configurable data width, bit order, a `tx_ready` handshake and an aborted-frame error flag.

---
 rtl/spi_slave_if.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_slave_if.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//
// SPI slave front-end placed between an SPI master and the RAM/register block.
// Each frame is 2 command bits followed by a DATA_W-bit payload. The frame is
// sampled on rising clk while ss_n is low. A read-address frame arms a later
// read-data frame. That read-data frame then returns DATA_W bits on MISO after a
// tx_valid/tx_ready handshake.
//
// Parameters
//   DATA_W     payload bits per frame (>= 2); a frame is DATA_W+2 bits long
//   LSB_FIRST  0: payload MSB-first on MOSI and MISO, 1: LSB-first
//
// Ports
//   clk                 system clock, also the SPI bit clock (rising edge)
//   rst_n               asynchronous active-low reset
//   ss_n                slave select, active low
//   MOSI                serial data in
//   MISO                serial data out (0 whenever not shifting)
//   rx_data             last complete frame {cmd[1:0], payload}
//   rx_valid            one-cycle strobe: rx_data was just loaded
//   tx_data             read data to return on MISO
//   tx_valid            tx_data is valid
//   tx_ready            slave can accept tx_data
//   frame_err           one-cycle strobe: ss_n rose during an unfinished frame
//   dbg_state_o         current FSM state (debug)
//   dbg_rd_addr_seen_o  read-address frame seen, read-data pending (debug)
//
// Handshake: tx_data is taken on a rising edge where tx_valid and tx_ready are
// both 1. tx_ready stays high until that edge and tx_valid is ignored while
// tx_ready is 0. Nothing is retracted by the slave except on ss_n rising.
// -----------------------------------------------------------------------------
module spi_slave_if #(
  parameter int          DATA_W    = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic [2:0]        dbg_state_o,
  output logic              dbg_rd_addr_seen_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  // Transmit sub-phase inside READ_DATA once the frame itself is complete.
  localparam logic [1:0] TX_NONE  = 2'd0;
  localparam logic [1:0] TX_WAIT  = 2'd1;
  localparam logic [1:0] TX_SHIFT = 2'd2;
  localparam logic [1:0] TX_DONE  = 2'd3;

  localparam int CNT_W    = $clog2(DATA_W + 3);
  localparam int TX_CNT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0]    FRAME_LEN = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0]    CMD0_BIT  = CNT_W'(1);
  localparam logic [TX_CNT_W-1:0] TX_LEN    = TX_CNT_W'(DATA_W);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;     // frame bits sampled so far
  logic                cmd1_q, cmd1_d;
  logic                cmd0_q, cmd0_d;
  logic [DATA_W-1:0]   pay_q, pay_d;
  logic [DATA_W+1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_seen_q, rd_seen_d;
  logic [1:0]          tx_phase_q, tx_phase_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;      // MISO bits driven so far
  logic                miso_q, miso_d;
  logic                frame_err_q, frame_err_d;

  // Bit-order dependent shift helpers.
  logic [DATA_W-1:0] pay_shift;
  logic              tx_load_bit;
  logic [DATA_W-1:0] tx_load_sr;
  logic              tx_next_bit;
  logic [DATA_W-1:0] tx_next_sr;

  always_comb begin
    if (LSB_FIRST != 0) begin
      pay_shift   = {MOSI, pay_q[DATA_W-1:1]};
      tx_load_bit = tx_data[0];
      tx_load_sr  = tx_data >> 1;
      tx_next_bit = tx_sr_q[0];
      tx_next_sr  = tx_sr_q >> 1;
    end else begin
      pay_shift   = {pay_q[DATA_W-2:0], MOSI};
      tx_load_bit = tx_data[DATA_W-1];
      tx_load_sr  = tx_data << 1;
      tx_next_bit = tx_sr_q[DATA_W-1];
      tx_next_sr  = tx_sr_q << 1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd1_d      = cmd1_q;
    cmd0_d      = cmd0_q;
    pay_d       = pay_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rd_seen_d   = rd_seen_q;
    tx_phase_d  = tx_phase_q;
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;

    if (ss_n) begin
      // Deselect wins over everything, including a same-edge handshake.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      tx_phase_d = TX_NONE;
      if (state_q != IDLE) begin
        if (bit_cnt_q != FRAME_LEN) begin
          frame_err_d = 1'b1;
        end else if (state_q == READ_DATA) begin
          if (tx_phase_q == TX_SHIFT && tx_cnt_q == TX_LEN) begin
            // Last MISO bit already spent its full cycle on the line.
            rd_seen_d = 1'b0;
          end else if (tx_phase_q != TX_DONE) begin
            frame_err_d = 1'b1;
          end
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
        end
        CHK_CMD: begin
          cmd1_d    = MOSI;
          bit_cnt_d = CMD0_BIT;
          if (!MOSI)          state_d = WRITE;
          else if (rd_seen_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q != FRAME_LEN) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CMD0_BIT) cmd0_d = MOSI;
            else                       pay_d  = pay_shift;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = {cmd1_q, cmd0_q, pay_shift};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_seen_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            case (tx_phase_q)
              TX_NONE: tx_phase_d = TX_WAIT;
              TX_WAIT: begin
                if (tx_valid) begin
                  miso_d     = tx_load_bit;
                  tx_sr_d    = tx_load_sr;
                  tx_cnt_d   = TX_CNT_W'(1);
                  tx_phase_d = TX_SHIFT;
                end
              end
              TX_SHIFT: begin
                if (tx_cnt_q == TX_LEN) begin
                  tx_phase_d = TX_DONE;
                  rd_seen_d  = 1'b0;
                end else begin
                  miso_d   = tx_next_bit;
                  tx_sr_d  = tx_next_sr;
                  tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
                end
              end
              default: ;
            endcase
          end
          // WRITE / READ_ADD past the frame: extra MOSI bits are ignored.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd1_q      <= 1'b0;
      cmd0_q      <= 1'b0;
      pay_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      tx_phase_q  <= TX_NONE;
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd1_q      <= cmd1_d;
      cmd0_q      <= cmd0_d;
      pay_q       <= pay_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rd_seen_q   <= rd_seen_d;
      tx_phase_q  <= tx_phase_d;
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO               = miso_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign tx_ready           = (tx_phase_q == TX_WAIT);
  assign frame_err          = frame_err_q;
  assign dbg_state_o        = state_q;
  assign dbg_rd_addr_seen_o = rd_seen_q;

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared serial inputs; both instances see the same bus.
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic tx_valid = 1'b0;

  logic        miso8, rx_valid8, tx_ready8, frame_err8, rd_seen8;
  logic [9:0]  rx_data8;
  logic [7:0]  tx_data8 = '0;
  logic [2:0]  state8;

  logic        miso16, rx_valid16, tx_ready16, frame_err16, rd_seen16;
  logic [17:0] rx_data16;
  logic [15:0] tx_data16 = '0;
  logic [2:0]  state16;

  int checks = 0;
  int errors = 0;

  spi_slave_if #(.DATA_W(8), .LSB_FIRST(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .MOSI(mosi), .MISO(miso8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data8),
    .tx_valid(tx_valid), .tx_ready(tx_ready8), .frame_err(frame_err8),
    .dbg_state_o(state8), .dbg_rd_addr_seen_o(rd_seen8)
  );

  spi_slave_if #(.DATA_W(16), .LSB_FIRST(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .MOSI(mosi), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16),
    .tx_valid(tx_valid), .tx_ready(tx_ready16), .frame_err(frame_err16),
    .dbg_state_o(state16), .dbg_rd_addr_seen_o(rd_seen16)
  );

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'b0;
  endtask

  // Sends bits[n-1] first; the last bit is sampled on the posedge after return.
  task automatic send_serial(input logic [17:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mosi = bits[i];
    end
  endtask

  // Returns at the negedge after the deselect edge (frame_err visible there).
  task automatic end_frame();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15 - i];
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso8); end
    checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid8); end
    checks++; if (tx_ready8 !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready8); end
    checks++; if (frame_err8 !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err8); end
    checks++; if (rx_data8 !== 10'h000) begin errors++; $display("FAIL reset_rx_data got=%h exp=000", rx_data8); end
    checks++; if (state8 !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state8, S_IDLE); end
    checks++; if (rd_seen8 !== 1'b0) begin errors++; $display("FAIL reset_rd_seen got=%b exp=0", rd_seen8); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_addr();
    start_frame();
    send_serial({8'h0, 10'b00_1111_1111}, 10);
    @(negedge clk);
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL wr_rx_valid got=%b exp=1", rx_valid8); end
    checks++; if (rx_data8 !== 10'h0FF) begin errors++; $display("FAIL wr_rx_data got=%h exp=0ff", rx_data8); end
    mosi = 1'b1;
    @(negedge clk);
    checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL wr_rx_valid_single got=%b exp=0", rx_valid8); end
    mosi = 1'b0;
    @(negedge clk);
    mosi = 1'b1;
    @(negedge clk);
    checks++; if (state8 !== S_WRITE) begin errors++; $display("FAIL wr_state_hold got=%0d exp=%0d", state8, S_WRITE); end
    checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL wr_extra_bits got=%b exp=0", rx_valid8); end
    end_frame();
    checks++; if (state8 !== S_IDLE) begin errors++; $display("FAIL wr_idle got=%0d exp=%0d", state8, S_IDLE); end
    checks++; if (frame_err8 !== 1'b0) begin errors++; $display("FAIL wr_no_err got=%b exp=0", frame_err8); end
  endtask

  task automatic test_read_seq();
    logic [0:7] seq;
    seq = 8'b1000_1011;
    start_frame();
    send_serial({8'h0, 10'b10_1010_0101}, 10);
    @(negedge clk);
    checks++; if (rx_data8 !== 10'h2A5) begin errors++; $display("FAIL rda_rx_data got=%h exp=2a5", rx_data8); end
    checks++; if (rd_seen8 !== 1'b1) begin errors++; $display("FAIL rda_rd_seen got=%b exp=1", rd_seen8); end
    checks++; if (state8 !== S_READ_ADD) begin errors++; $display("FAIL rda_state got=%0d exp=%0d", state8, S_READ_ADD); end
    end_frame();
    // tx_valid held high through the frame must be ignored until tx_ready.
    tx_data8 = 8'h8B;
    tx_valid = 1'b1;
    start_frame();
    send_serial({8'h0, 10'b11_0000_0000}, 10);
    @(negedge clk);
    checks++; if (rx_data8 !== 10'h300) begin errors++; $display("FAIL rdd_rx_data got=%h exp=300", rx_data8); end
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL rdd_rx_valid got=%b exp=1", rx_valid8); end
    checks++; if (tx_ready8 !== 1'b0) begin errors++; $display("FAIL rdd_tx_ready_early got=%b exp=0", tx_ready8); end
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rdd_miso_idle got=%b exp=0", miso8); end
    @(negedge clk);
    checks++; if (tx_ready8 !== 1'b1) begin errors++; $display("FAIL rdd_tx_ready got=%b exp=1", tx_ready8); end
    checks++; if (state8 !== S_READ_DATA) begin errors++; $display("FAIL rdd_state got=%0d exp=%0d", state8, S_READ_DATA); end
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rdd_miso_wait got=%b exp=0", miso8); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checks++; if (miso8 !== seq[i]) begin errors++; $display("FAIL rdd_miso_bit%0d got=%b exp=%b", i, miso8, seq[i]); end
      if (i == 0) begin
        checks++; if (tx_ready8 !== 1'b0) begin errors++; $display("FAIL rdd_tx_ready_drop got=%b exp=0", tx_ready8); end
      end
    end
    @(negedge clk);
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rdd_miso_after got=%b exp=0", miso8); end
    checks++; if (rd_seen8 !== 1'b0) begin errors++; $display("FAIL rdd_rd_seen_clear got=%b exp=0", rd_seen8); end
    @(negedge clk);
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rdd_miso_hold0 got=%b exp=0", miso8); end
    end_frame();
    checks++; if (frame_err8 !== 1'b0) begin errors++; $display("FAIL rdd_no_err got=%b exp=0", frame_err8); end
  endtask

  task automatic test_abort();
    start_frame();
    send_serial({13'h0, 5'b01_101}, 5);
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_err8 !== 1'b1) begin errors++; $display("FAIL abort_err got=%b exp=1", frame_err8); end
    checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL abort_rx_valid got=%b exp=0", rx_valid8); end
    checks++; if (state8 !== S_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=%0d", state8, S_IDLE); end
    @(negedge clk);
    checks++; if (frame_err8 !== 1'b0) begin errors++; $display("FAIL abort_err_single got=%b exp=0", frame_err8); end
    start_frame();
    send_serial({8'h0, 10'b01_0011_1100}, 10);
    @(negedge clk);
    checks++; if (rx_data8 !== 10'h13C) begin errors++; $display("FAIL abort_next_rx_data got=%h exp=13c", rx_data8); end
    checks++; if (rx_valid8 !== 1'b1) begin errors++; $display("FAIL abort_next_rx_valid got=%b exp=1", rx_valid8); end
    end_frame();
  endtask

  task automatic test_simultaneous();
    start_frame();
    send_serial({8'h0, 10'b10_0001_0001}, 10);
    end_frame();
    start_frame();
    send_serial({8'h0, 10'b11_0000_0000}, 10);
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx_ready8 !== 1'b1) begin errors++; $display("FAIL simul_tx_ready got=%b exp=1", tx_ready8); end
    tx_data8 = 8'hFF;
    tx_valid = 1'b1;
    ss_n = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (frame_err8 !== 1'b1) begin errors++; $display("FAIL simul_err got=%b exp=1", frame_err8); end
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL simul_miso got=%b exp=0", miso8); end
    checks++; if (rd_seen8 !== 1'b1) begin errors++; $display("FAIL simul_rd_seen got=%b exp=1", rd_seen8); end
    checks++; if (state8 !== S_IDLE) begin errors++; $display("FAIL simul_state got=%0d exp=%0d", state8, S_IDLE); end
    @(negedge clk);
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL simul_miso_later got=%b exp=0", miso8); end
  endtask

  task automatic test_reset_mid();
    start_frame();
    send_serial({8'h0, 10'b11_0000_0000}, 10);
    @(negedge clk);
    @(negedge clk);
    tx_data8 = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (miso8 !== 1'b1) begin errors++; $display("FAIL rstmid_shifting got=%b exp=1", miso8); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rstmid_miso got=%b exp=0", miso8); end
    checks++; if (rx_data8 !== 10'h000) begin errors++; $display("FAIL rstmid_rx_data got=%h exp=000", rx_data8); end
    checks++; if (state8 !== S_IDLE) begin errors++; $display("FAIL rstmid_state got=%0d exp=%0d", state8, S_IDLE); end
    checks++; if (rd_seen8 !== 1'b0) begin errors++; $display("FAIL rstmid_rd_seen got=%b exp=0", rd_seen8); end
    checks++; if (frame_err8 !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", frame_err8); end
    @(negedge clk);
    ss_n = 1'b1;
    rst_n = 1'b1;
    start_frame();
    send_serial({17'h0, 1'b1}, 1);
    @(negedge clk);
    checks++; if (state8 !== S_READ_ADD) begin errors++; $display("FAIL rstmid_next_state got=%0d exp=%0d", state8, S_READ_ADD); end
    end_frame();
  endtask

  task automatic test_wide_lsb();
    logic [0:15] seq;
    seq = 16'b1111_0111_0111_1101;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    send_serial({2'b01, rev16(16'h1234)}, 18);
    @(negedge clk);
    checks++; if (rx_data16 !== 18'h11234) begin errors++; $display("FAIL wide_rx_data got=%h exp=11234", rx_data16); end
    checks++; if (rx_valid16 !== 1'b1) begin errors++; $display("FAIL wide_rx_valid got=%b exp=1", rx_valid16); end
    end_frame();
    start_frame();
    send_serial(18'h20000, 18);
    end_frame();
    checks++; if (rd_seen16 !== 1'b1) begin errors++; $display("FAIL wide_rd_seen got=%b exp=1", rd_seen16); end
    start_frame();
    send_serial(18'h30000, 18);
    @(negedge clk);
    checks++; if (rx_data16 !== 18'h30000) begin errors++; $display("FAIL wide_rdd_rx_data got=%h exp=30000", rx_data16); end
    @(negedge clk);
    checks++; if (tx_ready16 !== 1'b1) begin errors++; $display("FAIL wide_tx_ready got=%b exp=1", tx_ready16); end
    tx_data16 = 16'hBEEF;
    tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checks++; if (miso16 !== seq[i]) begin errors++; $display("FAIL wide_miso_bit%0d got=%b exp=%b", i, miso16, seq[i]); end
    end
    @(negedge clk);
    checks++; if (miso16 !== 1'b0) begin errors++; $display("FAIL wide_miso_after got=%b exp=0", miso16); end
    checks++; if (rd_seen16 !== 1'b0) begin errors++; $display("FAIL wide_rd_seen_clear got=%b exp=0", rd_seen16); end
    end_frame();
    checks++; if (frame_err16 !== 1'b0) begin errors++; $display("FAIL wide_no_err got=%b exp=0", frame_err16); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_addr();
    test_read_seq();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    test_wide_lsb();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
